// File: rtl/led_frame_ctrl_if.sv
// Pixel-write and command bundle between the game/overlay logic and the frame controller.
// Two requesters share the back buffer; the master drives requests and the slave returns readies.
interface led_frame_ctrl_if;
  logic       req0_valid;
  logic [3:0] req0_x;
  logic [3:0] req0_y;
  logic [1:0] req0_color;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_x;
  logic [3:0] req1_y;
  logic [1:0] req1_color;
  logic       req1_ready;
  logic       clear_req;
  logic       commit_req;

  modport master (
    output req0_valid, req0_x, req0_y, req0_color,
    output req1_valid, req1_x, req1_y, req1_color,
    output clear_req, commit_req,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_color,
    input  req1_valid, req1_x, req1_y, req1_color,
    input  clear_req, commit_req,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/led_frame_ctrl.sv
// Double-buffered 16x16 red/green frame controller: arbitrated pixel writes into a back buffer,
// published to the front buffer on the first frame_tick after a commit.
module led_frame_ctrl #(
  parameter bit AUTO_CLEAR = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 frame_tick,
  led_frame_ctrl_if.slave      bus,
  output logic                 busy,
  output logic [15:0][15:0]    RedPixels,
  output logic [15:0][15:0]    GrnPixels,
  output logic [CNT_W-1:0]     frame_count
);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_TICK, SWAP} state_t;

  state_t            state_q, state_d;
  logic [15:0][15:0] back_red_q, back_red_d;
  logic [15:0][15:0] back_grn_q, back_grn_d;
  logic [15:0][15:0] front_red_q, front_red_d;
  logic [15:0][15:0] front_grn_q, front_grn_d;
  logic [3:0]        row_q, row_d;
  logic              rr_q, rr_d;
  logic              commit_pending_q, commit_pending_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              gnt0, gnt1;

  always_comb begin
    state_d          = state_q;
    back_red_d       = back_red_q;
    back_grn_d       = back_grn_q;
    front_red_d      = front_red_q;
    front_grn_d      = front_grn_q;
    row_d            = row_q;
    rr_d             = rr_q;
    commit_pending_d = commit_pending_q;
    count_d          = count_q;
    gnt0             = 1'b0;
    gnt1             = 1'b0;

    case (state_q)
      IDLE: begin
        // Commands pre-empt writes: no requester is granted on a command cycle.
        if (bus.clear_req) begin
          state_d          = CLEAR;
          commit_pending_d = bus.commit_req;
        end else if (bus.commit_req) begin
          state_d = WAIT_TICK;
        end else begin
          gnt0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
          gnt1 = bus.req1_valid && (!bus.req0_valid || rr_q);
          if (gnt0) begin
            back_red_d[bus.req0_x][bus.req0_y] = bus.req0_color[0];
            back_grn_d[bus.req0_x][bus.req0_y] = bus.req0_color[1];
            rr_d = 1'b1;
          end else if (gnt1) begin
            back_red_d[bus.req1_x][bus.req1_y] = bus.req1_color[0];
            back_grn_d[bus.req1_x][bus.req1_y] = bus.req1_color[1];
            rr_d = 1'b0;
          end
        end
      end
      CLEAR: begin
        back_red_d[row_q] = '0;
        back_grn_d[row_q] = '0;
        row_d             = row_q + 4'd1;
        if (row_q == 4'd15) begin
          state_d          = commit_pending_q ? WAIT_TICK : IDLE;
          commit_pending_d = 1'b0;
        end
      end
      WAIT_TICK: begin
        if (frame_tick) state_d = SWAP;
      end
      SWAP: begin
        front_red_d = back_red_q;
        front_grn_d = back_grn_q;
        count_d     = count_q + CNT_W'(1);
        state_d     = AUTO_CLEAR ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q          <= IDLE;
      back_red_q       <= '0;
      back_grn_q       <= '0;
      front_red_q      <= '0;
      front_grn_q      <= '0;
      row_q            <= '0;
      rr_q             <= 1'b0;
      commit_pending_q <= 1'b0;
      busy_q           <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      back_red_q       <= back_red_d;
      back_grn_q       <= back_grn_d;
      front_red_q      <= front_red_d;
      front_grn_q      <= front_grn_d;
      row_q            <= row_d;
      rr_q             <= rr_d;
      commit_pending_q <= commit_pending_d;
      busy_q           <= busy_d;
      count_q          <= count_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign busy           = busy_q;
  assign RedPixels      = front_red_q;
  assign GrnPixels      = front_grn_q;
  assign frame_count    = count_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Bench for led_frame_ctrl: directed sequence with randomized pixel traffic, checked against
// an array-based model of the back/front buffers, swap counter and round-robin pointer.
module tb_led_frame_ctrl;

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic              frame_tick = 1'b0;
  logic              busy;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic [1:0]        frame_count;

  led_frame_ctrl_if bus ();

  led_frame_ctrl #(.AUTO_CLEAR(1'b0), .CNT_W(2)) dut (
    .clk         (clk),
    .RST         (RST),
    .frame_tick  (frame_tick),
    .bus         (bus),
    .busy        (busy),
    .RedPixels   (RedPixels),
    .GrnPixels   (GrnPixels),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [15:0][15:0] mbr, mbg, mfr, mfg;
  int mcount;
  int ptr;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mbr = '0; mbg = '0; mfr = '0; mfg = '0;
    mcount = 0;
    ptr = 0;
  endtask

  task automatic chk_front(input string tag);
    chk_frame({tag, "_red"}, RedPixels, mfr);
    chk_frame({tag, "_grn"}, GrnPixels, mfg);
  endtask

  // One IDLE cycle of write traffic, no commands.
  task automatic wr(input bit v0, input logic [3:0] x0, input logic [3:0] y0, input logic [1:0] c0,
                    input bit v1, input logic [3:0] x1, input logic [3:0] y1, input logic [1:0] c1);
    int g;
    bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0; bus.req0_color = c0;
    bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1; bus.req1_color = c1;
    #1;
    g = -1;
    if (v0 && v1) g = ptr;
    else if (v0) g = 0;
    else if (v1) g = 1;
    chk("ready0", int'(bus.req0_ready), int'(g == 0));
    chk("ready1", int'(bus.req1_ready), int'(g == 1));
    if (g == 0) begin
      mbr[x0][y0] = c0[0]; mbg[x0][y0] = c0[1]; ptr = 1;
    end else if (g == 1) begin
      mbr[x1][y1] = c1[0]; mbg[x1][y1] = c1[1]; ptr = 0;
    end
    cyc();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic rnd_wr(input bit force_both);
    bit v0, v1;
    v0 = force_both ? 1'b1 : 1'($urandom_range(1));
    v1 = force_both ? 1'b1 : 1'($urandom_range(1));
    wr(v0, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)),
       v1, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
  endtask

  // Commit, wait `delay` cycles in WAIT_TICK, tick, and verify the swap timing.
  task automatic commit_and_swap(input int delay, input bit hold1);
    bus.commit_req = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_x = 4'($urandom_range(15)); bus.req0_y = 4'($urandom_range(15));
    bus.req0_color = 2'b11;
    #1;
    chk("commit_ready0", int'(bus.req0_ready), 0);
    cyc();
    bus.commit_req = 1'b0;
    bus.req0_valid = 1'b0;
    chk("commit_busy", int'(busy), 1);
    for (int i = 0; i < delay; i++) begin
      if (hold1) begin
        bus.req1_valid = 1'b1;
        bus.req1_x = 4'($urandom_range(15)); bus.req1_y = 4'($urandom_range(15));
        bus.req1_color = 2'($urandom_range(3));
        #1;
        chk("wait_ready1", int'(bus.req1_ready), 0);
      end
      cyc();
    end
    bus.req1_valid = 1'b0;
    chk_front("pre_tick");
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk_front("tick_edge");
    chk("tick_edge_count", int'(frame_count), mcount);
    cyc();
    mfr = mbr; mfg = mbg;
    mcount = (mcount + 1) % 4;
    chk_front("swap");
    chk("swap_count", int'(frame_count), mcount);
    chk("swap_busy", int'(busy), 0);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_color = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_color = '0;
    bus.clear_req = 1'b0; bus.commit_req = 1'b0;
    model_reset();

    // Reset then idle
    repeat (2) cyc();
    RST = 1'b0;
    cyc();
    chk_front("reset");
    chk("reset_count", int'(frame_count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready0", int'(bus.req0_ready), 0);
    chk("reset_ready1", int'(bus.req1_ready), 0);

    // frame_tick while IDLE does nothing
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    chk("idle_tick_count", int'(frame_count), 0);
    chk("idle_tick_busy", int'(busy), 0);

    // Single write + commit
    wr(1'b1, 4'd3, 4'd5, 2'b11, 1'b0, 4'd0, 4'd0, 2'b00);
    chk_front("write_no_front");
    commit_and_swap(4, 1'b0);
    chk("pix35_red", int'(RedPixels[3][5]), 1);
    chk("pix35_grn", int'(GrnPixels[3][5]), 1);

    // Random traffic rounds, second one with writes held during WAIT_TICK
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) rnd_wr(1'b0);
      commit_and_swap($urandom_range(5), r == 1);
    end

    // Standalone clear: 16 busy cycles, readies low on the command cycle
    bus.clear_req = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    chk("clear_ready0", int'(bus.req0_ready), 0);
    cyc();
    bus.clear_req = 1'b0;
    bus.req0_valid = 1'b0;
    mbr = '0; mbg = '0;
    repeat (15) cyc();
    chk("clear_busy15", int'(busy), 1);
    cyc();
    chk("clear_busy16", int'(busy), 0);
    commit_and_swap(2, 1'b0);

    // Fill back buffer with 1s, then clear+commit together
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        wr(1'b1, 4'(x), 4'(y), 2'b11, 1'b0, 4'd0, 4'd0, 2'b00);
    bus.clear_req = 1'b1;
    bus.commit_req = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("cc_ready1", int'(bus.req1_ready), 0);
    cyc();
    bus.clear_req = 1'b0;
    bus.commit_req = 1'b0;
    mbr = '0; mbg = '0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("cc_clear_ready1", int'(bus.req1_ready), 0);
      cyc();
    end
    bus.req1_valid = 1'b0;
    chk("cc_busy", int'(busy), 1);
    // Tick on the last CLEAR row must be ignored
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("cc_ignored_tick", int'(frame_count), mcount);
    chk("cc_wait_busy", int'(busy), 1);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("cc_tick_count", int'(frame_count), mcount);
    cyc();
    mfr = mbr; mfg = mbg;
    mcount = (mcount + 1) % 4;
    chk_front("cc_swap");
    chk("cc_swap_count", int'(frame_count), mcount);
    chk("cc_swap_busy", int'(busy), 0);

    // Reset mid-CLEAR: back-buffer rows 12..15 hold data the clear has not reached
    for (int y = 0; y < 16; y++)
      wr(1'b0, 4'd0, 4'd0, 2'b00, 1'b1, 4'(12 + (y % 4)), 4'(y), 2'b11);
    bus.clear_req = 1'b1;
    cyc();
    bus.clear_req = 1'b0;
    repeat (7) cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    model_reset();
    chk_front("midclear_reset");
    chk("midclear_count", int'(frame_count), 0);
    chk("midclear_busy", int'(busy), 0);
    commit_and_swap(1, 1'b0);

    // Contention after reset starts with req0 and alternates
    for (int i = 0; i < 4; i++) rnd_wr(1'b1);

    // Three more swaps take the 2-bit counter through 2, 3 and back to 0
    for (int i = 0; i < 3; i++) commit_and_swap(i, 1'b0);
    chk("wrap_count", int'(frame_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
